// File: rtl/fill_ones_pkg.sv
// Shared definitions for the serial word-building blocks.
// State encoding lives here so every serial block agrees on it.
package fill_ones_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StFill = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fill_ones_ser.sv
// Serially builds a word whose low n bits are ones, one bit per clock.
// Requests above data_width saturate to all ones and raise sat with done.
module fill_ones_ser
  import fill_ones_pkg::*;
#(
  parameter int unsigned data_width  = 4,
  parameter int unsigned count_width = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [count_width-1:0] count_in,
  output logic [data_width-1:0]  data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  // Index must reach data_width without wrapping.
  localparam int unsigned IdxW = $clog2(data_width + 1);
  localparam logic [count_width-1:0] DwCnt = count_width'(data_width);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(data_width - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  fill_state_e           state_q, state_d;
  logic [IdxW-1:0]       n_q, n_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [data_width-1:0] shreg_q, shreg_d;
  logic [data_width-1:0] data_out_q, data_out_d;
  logic                  sat_pend_q, sat_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sat_q, sat_d;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    sat_pend_d = sat_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sat_d      = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count_in > DwCnt) begin
            n_d        = IdxW'(data_width);
            sat_pend_d = 1'b1;
          end else begin
            n_d        = IdxW'(count_in);
            sat_pend_d = 1'b0;
          end
          shreg_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        // Bit inserted at step i ends up at position i after the last shift.
        shreg_d                 = shreg_q >> 1;
        shreg_d[data_width-1]   = (idx_q < n_q);
        idx_d                   = idx_q + IdxOne;
        if (idx_q == LastIdx) begin
          data_out_d = shreg_d;
          done_d     = 1'b1;
          sat_d      = sat_pend_q;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      sat_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      sat_pend_q <= sat_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_fill_ones_ser.sv
// Directed and randomized checks of fill_ones_ser against an arithmetic model.
module tb_fill_ones_ser;

  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] count_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          sat;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_word = '0;

  fill_ones_ser #(
    .data_width (DW),
    .count_width(CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .count_in(count_in),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int c);
    if (c >= DW) return (32'd1 << DW) - 32'd1;
    return (32'd1 << c) - 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has already driven start=1 and count_in=cnt before the sampling edge.
  task automatic op(input int cnt, input bit scramble, input bit chain, input int nxt);
    logic [31:0] ew;
    logic [31:0] es;
    ew = exp_word(cnt);
    es = (cnt > DW) ? 32'd1 : 32'd0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      chk("fill_busy", {31'd0, busy}, 32'd1);
      chk("fill_done", {31'd0, done}, 32'd0);
      chk("fill_hold", {28'd0, data_out}, prev_word);
      if (scramble) begin
        start    = 1'($urandom);
        count_in = CW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("result", {28'd0, data_out}, ew);
    chk("sat", {31'd0, sat}, es);
    prev_word = ew;
    if (chain) begin
      start    = 1'b1;
      count_in = CW'(nxt);
    end else begin
      start = 1'b0;
      @(negedge clk);
      chk("done_low", {31'd0, done}, 32'd0);
      chk("idle_hold", {28'd0, data_out}, ew);
    end
  endtask

  initial begin
    int cur;
    int nxt;
    bit ch;
    reset    = 1'b0;
    start    = 1'b1;
    count_in = 3'd3;
    repeat (2) begin
      @(negedge clk);
      chk("rst_data", {28'd0, data_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sat", {31'd0, sat}, 32'd0);
    end
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);

    // Basic and boundary counts.
    start = 1'b1; count_in = 3'd2; op(2, 1'b0, 1'b0, 0);
    start = 1'b1; count_in = 3'd0; op(0, 1'b0, 1'b0, 0);
    start = 1'b1; count_in = 3'd4; op(4, 1'b0, 1'b0, 0);
    start = 1'b1; count_in = 3'd7; op(7, 1'b0, 1'b0, 0);

    // Back-to-back: second start held in the done cycle.
    start = 1'b1; count_in = 3'd1; op(1, 1'b0, 1'b1, 3);
    op(3, 1'b0, 1'b0, 0);

    // Inputs toggling during FILL must not disturb the captured count.
    start = 1'b1; count_in = 3'd2; op(2, 1'b1, 1'b0, 0);

    // Abort mid-operation.
    start = 1'b1; count_in = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_data", {28'd0, data_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sat", {31'd0, sat}, 32'd0);
    reset     = 1'b1;
    prev_word = '0;
    repeat (DW + 1) begin
      @(negedge clk);
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    start = 1'b1; count_in = 3'd1; op(1, 1'b0, 1'b0, 0);

    // Randomized sequence with random chaining and scrambling.
    cur      = int'($urandom_range(0, 7));
    start    = 1'b1;
    count_in = CW'(cur);
    for (int k = 0; k < 16; k++) begin
      nxt = int'($urandom_range(0, 7));
      ch  = (k < 15) && ($urandom_range(0, 1) == 1);
      op(cur, 1'($urandom), ch, nxt);
      if (!ch && k < 15) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("gap_hold", {28'd0, data_out}, prev_word);
        end
        start    = 1'b1;
        count_in = CW'(nxt);
      end
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
